// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle control sequencer: FSM states,
// RV32I opcodes and the select codes driven onto the datapath.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_JUMP = 2'b11;

    localparam logic [1:0] PCSRC_PLUS4 = 2'b00;
    localparam logic [1:0] PCSRC_IMM   = 2'b01;
    localparam logic [1:0] PCSRC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/instr_legality_check.sv
// Combinational legality decode for the supported RV32I subset; kept apart
// from the sequencer so a pipelined decoder can reuse it.
module instr_legality_check
    import multicycle_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       legal
);

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct3 inside {3'b000, 3'b001, 3'b101, 3'b110, 3'b111}) begin
                    // Alternate funct7 only exists for sub and sra.
                    legal = (funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) && (funct3 inside {3'b000, 3'b101}));
                end
            end
            OP_IALU: begin
                if (funct3 == 3'b101) begin
                    legal = ~funct7[5];
                end else begin
                    legal = funct3 inside {3'b000, 3'b001, 3'b111};
                end
            end
            OP_LOAD:          legal = funct3 inside {3'b000, 3'b010, 3'b100};
            OP_STORE:         legal = funct3 inside {3'b000, 3'b010};
            OP_BRANCH:        legal = funct3 inside {3'b000, 3'b001, 3'b100, 3'b101};
            OP_JAL, OP_JALR:  legal = 1'b1;
            default:          legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the shared single-ALU datapath.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 0,
    parameter int unsigned CNT_WIDTH   = 32
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instrIn,
    input  logic                 memReady,
    input  logic                 zeroFlag,
    output logic                 memReq,
    output logic                 memRead,
    output logic                 memWrite,
    output logic                 iorD,
    output logic                 irWrite,
    output logic                 regWrite,
    output logic [1:0]           wbSel,
    output logic                 pcWrite,
    output logic [1:0]           pcSrc,
    output logic [1:0]           ALUOp,
    output logic                 ALUSrc,
    output logic [2:0]           funct3,
    output logic                 i30,
    output logic [31:0]          instr,
    output logic                 illegalInstr,
    output logic                 busError,
    output logic [CNT_WIDTH-1:0] instret,
    output logic [2:0]           state_out
);

    state_t                 r_state;
    state_t                 w_next;
    logic [31:0]            r_instr;
    logic [CNT_WIDTH-1:0]   r_instret;
    logic                   r_illegal;
    logic                   r_bus_err;
    logic [31:0]            r_stall_cnt;

    logic [6:0]             w_opcode;
    logic                   w_legal;
    logic                   w_is_r;
    logic                   w_is_load;
    logic                   w_is_store;
    logic                   w_taken;
    logic                   w_waiting;
    logic [31:0]            w_stall_inc;
    logic                   w_timeout;
    logic                   w_retire;
    logic                   w_set_illegal;
    logic                   w_set_bus_err;

    assign w_opcode   = r_instr[6:0];
    assign w_is_r     = (w_opcode == OP_R);
    assign w_is_load  = (w_opcode == OP_LOAD);
    assign w_is_store = (w_opcode == OP_STORE);
    assign w_taken    = (r_instr[14:12] == 3'b001) ? ~zeroFlag : zeroFlag;

    // The stall counter restarts on every state entry, so it only ever
    // measures the current wait on memReady.
    assign w_waiting   = ((r_state == S_FETCH) || (r_state == S_MEM)) && !memReady;
    assign w_stall_inc = r_stall_cnt + 32'd1;
    assign w_timeout   = (STALL_LIMIT != 0) && w_waiting && (w_stall_inc == STALL_LIMIT);

    instr_legality_check u_legality (
        .opcode (w_opcode),
        .funct3 (r_instr[14:12]),
        .funct7 (r_instr[31:25]),
        .legal  (w_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_instr     <= 32'd0;
            r_instret   <= '0;
            r_illegal   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_stall_cnt <= 32'd0;
        end else begin
            r_state <= w_next;
            if (irWrite) r_instr <= instrIn;
            if (w_retire) r_instret <= r_instret + CNT_WIDTH'(1);
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_bus_err) r_bus_err <= 1'b1;
            if (w_next != r_state) begin
                r_stall_cnt <= 32'd0;
            end else if (w_waiting) begin
                r_stall_cnt <= w_stall_inc;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        memReq        = 1'b0;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        iorD          = 1'b0;
        irWrite       = 1'b0;
        regWrite      = 1'b0;
        wbSel         = WB_ALU;
        pcWrite       = 1'b0;
        pcSrc         = PCSRC_PLUS4;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                memReq  = 1'b1;
                memRead = 1'b1;
                if (memReady) begin
                    irWrite = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_DECODE: begin
                w_set_illegal = !w_legal;
                w_next        = w_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (w_opcode)
                    OP_R, OP_IALU:     w_next = S_WB;
                    OP_LOAD, OP_STORE: w_next = S_MEM;
                    OP_BRANCH: begin
                        pcWrite  = 1'b1;
                        pcSrc    = w_taken ? PCSRC_IMM : PCSRC_PLUS4;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    OP_JAL, OP_JALR: begin
                        regWrite = 1'b1;
                        wbSel    = WB_PC4;
                        pcWrite  = 1'b1;
                        pcSrc    = (w_opcode == OP_JAL) ? PCSRC_IMM : PCSRC_ALU;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                memReq   = 1'b1;
                iorD     = 1'b1;
                memRead  = w_is_load;
                memWrite = w_is_store;
                if (memReady) begin
                    if (w_is_store) begin
                        pcWrite  = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                wbSel    = w_is_load ? WB_MEM : WB_ALU;
                pcWrite  = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ALUOp  = ALUOP_ADD;
        ALUSrc = 1'b0;
        if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
            case (w_opcode)
                OP_R:                       ALUOp = ALUOP_R;
                OP_IALU, OP_LOAD, OP_STORE: ALUSrc = 1'b1;
                OP_BRANCH:                  ALUOp = ALUOP_BR;
                OP_JAL, OP_JALR: begin
                    ALUOp  = ALUOP_JUMP;
                    ALUSrc = 1'b1;
                end
                default: begin
                    ALUOp  = ALUOP_ADD;
                    ALUSrc = 1'b0;
                end
            endcase
        end
    end

    assign funct3       = r_instr[14:12];
    assign i30          = w_is_r & r_instr[30];
    assign instr        = r_instr;
    assign illegalInstr = r_illegal;
    assign busError     = r_bus_err;
    assign instret      = r_instret;
    assign state_out    = r_state;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control sequencer: the producer side of the ALU control interface (ALUOp, ALUSrc, funct3, i30), and the consumer of zeroFlag.
- Holds the instruction register and steps each RV32I-subset instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives memory handshake, register-file, PC and writeback selects for the shared single-ALU datapath.
- Flags illegal instructions and memory stalls.

Parameters:
STALL_LIMIT, 0, max cycles waiting on memReady before bus error; 0 disables the timeout
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
instrIn  input  32  memory read data, captured as instruction in FETCH
memReady  input  1  memory accepts/completes current request this cycle
zeroFlag  input  1  ALU condition output
memReq  output  1  memory request valid
memRead  output  1  read request
memWrite  output  1  write request
iorD  output  1  0 = PC address, 1 = ALU result address
irWrite  output  1  instruction register load strobe
regWrite  output  1  register-file write strobe
wbSel  output  2  00 ALU result, 01 memory data, 10 PC+4
pcWrite  output  1  PC update strobe
pcSrc  output  2  00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared
ALUOp  output  2  to ALU control
ALUSrc  output  1  0 = rs2, 1 = immediate
funct3  output  3  instruction[14:12]
i30  output  1  instruction[30] for R-type, else 0
instr  output  32  instruction register contents
illegalInstr  output  1  sticky, unsupported encoding trapped
busError  output  1  sticky, memory stall timeout
instret  output  CNT_WIDTH  retired instruction count
state_out  output  3  current state encoding, for debug

Behaviour:
- Reset (async): state = IDLE; instr = 0; instret = 0; illegalInstr = busError = 0.
- Reset effect on strobes: all strobes are 0 in IDLE. Reset mid-transaction drops memReq immediately.
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, TRAP 6.
- Outputs are combinational from state and instr.
- IDLE -> FETCH unconditionally.
- FETCH: memReq = memRead = 1, iorD = 0.
  - Stay until memReady = 1.
  - On memReady: irWrite = 1, instr <= instrIn, -> DECODE.
- DECODE: no strobes. Legality check:
  - R-type 0110011: funct3 in {000,001,101,110,111}; funct7 is 0000000, or 0100000 only for funct3 000/101.
  - I-ALU 0010011: funct3 in {000,001,101,111}; funct3 101 requires instr[30] = 0.
  - Load 0000011: funct3 in {000,010,100}.
  - Store 0100011: funct3 in {000,010}.
  - Branch 1100011: funct3 in {000,001,100,101}.
  - jal 1101111 and jalr 1100111 are legal.
  - Illegal -> TRAP. Legal -> EXEC.
- ALU drive in EXEC/MEM/WB:
  - R-type: ALUOp 10, ALUSrc 0.
  - I-ALU, load, store: ALUOp 00, ALUSrc 1.
  - Branch: ALUOp 01, ALUSrc 0.
  - jal/jalr: ALUOp 11, ALUSrc 1.
- ALU drive elsewhere: ALUOp 00, ALUSrc 0.
- EXEC actions:
  - R/I-ALU, load, store -> WB or MEM.
  - Branch: taken = (funct3 == 001) ? ~zeroFlag : zeroFlag. pcWrite = 1, pcSrc = taken ? 01 : 00; retire; -> FETCH.
  - jal: regWrite = 1, wbSel = 10, pcWrite = 1, pcSrc = 01; retire; -> FETCH.
  - jalr: same as jal but pcSrc = 10.
- MEM: memReq = 1, iorD = 1; memRead (load) or memWrite (store).
  - Stay until memReady = 1.
  - Store completes with pcWrite = 1, pcSrc = 00; retire; -> FETCH.
  - Load -> WB.
- WB: regWrite = 1, wbSel = 01 (load) or 00 (ALU); pcWrite = 1, pcSrc = 00; retire; -> FETCH.
- Retire: instret increments by 1 in the retiring cycle and wraps modulo 2^CNT_WIDTH.
- Request stability: while waiting for memReady, all request outputs are held stable.
- Stall timeout: stall counter clears on state entry. When STALL_LIMIT > 0 and the counter reaches STALL_LIMIT with memReady still 0: busError = 1, -> TRAP.
- TRAP: all strobes 0; held until reset.
- Minimum latencies:
  - Branch, jal, jalr: 3 cycles.
  - ALU ops, store: 4 cycles.
  - Load: 5 cycles.

Decomposition:
- Package multicycle_pkg holds:
  - state encoding constants;
  - opcode constants;
  - ALUOp codes 00/01/10/11;
  - pcSrc and wbSel codes.
- Sub-module instr_legality_check: combinational legality decode of instr. Separates legality from the FSM and is reusable by a future pipelined decoder.

Test Plan:
- add x3,x1,x2 (0x002081B3), memReady = 1 always -> FETCH, DECODE, EXEC, WB. WB cycle: regWrite = 1, wbSel = 00, ALUOp = 10, i30 = 0, pcSrc = 00. instret 0 -> 1.
- bne x1,x2 (funct3 001), zeroFlag = 1 in EXEC -> pcWrite = 1, pcSrc = 00. Repeat with zeroFlag = 0 -> pcSrc = 01. ALUOp = 01 both times.
- lw, memReady held low for 3 cycles in MEM -> memReq/memRead/iorD = 1 and stable for all 4 MEM cycles. Next cycle WB with wbSel = 01.
- srai (0x4010D093) -> illegalInstr = 1 after DECODE. State 6 persists, no strobes, instret unchanged until rst.
- STALL_LIMIT = 4, memReady = 0 in FETCH -> busError = 1 and TRAP after 4 waiting cycles.
- rst asserted mid-MEM during a store -> memWrite and memReq drop immediately. After release: IDLE, then FETCH; instret = 0.
